// File: rtl/decoder3x8_seq_if.sv
// Code-in / one-hot-out bundle for decoder3x8_seq; master is the code source.
// in_parity exists only when DEC_PARITY_EN is defined.
interface decoder3x8_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
`ifdef DEC_PARITY_EN
  logic       in_parity;
`endif
  logic [7:0] out;
  logic       out_valid;

`ifdef DEC_PARITY_EN
  modport master (output in_valid, in_code, in_parity, input in_ready, out, out_valid);
  modport slave  (input in_valid, in_code, in_parity, output in_ready, out, out_valid);
`else
  modport master (output in_valid, in_code, input in_ready, out, out_valid);
  modport slave  (input in_valid, in_code, output in_ready, out, out_valid);
`endif
endinterface

// File: rtl/decoder3x8_seq.sv
// Sequenced 3:8 decoder: each accepted code drives a registered one-hot word for HOLD_CYCLES clocks.
// Optional DEC_PARITY_EN adds even-parity checking of in_code with a one-cycle err pulse.
module decoder3x8_seq #(
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  decoder3x8_seq_if.slave dec,
`ifdef DEC_PARITY_EN
  output logic            err,
`endif
  output logic            busy
);
  localparam int               HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [7:0]       word, word_nx;
  logic             accept;
  logic             code_ok;

  assign accept = dec.in_valid & dec.in_ready;

`ifdef DEC_PARITY_EN
  logic err_q;
  assign code_ok = ~^{dec.in_parity, dec.in_code};
`else
  assign code_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      word  <= '0;
`ifdef DEC_PARITY_EN
      err_q <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      word  <= word_nx;
`ifdef DEC_PARITY_EN
      err_q <= accept & ~code_ok;
`endif
    end
  end

  // A code with bad parity is treated as if nothing was accepted.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    word_nx  = word;
    case (state)
      IDLE: begin
        if (accept && code_ok) begin
          state_nx = HOLD;
          cnt_nx   = CNT_LOAD;
          word_nx  = 8'b1 << dec.in_code;
        end
      end
      HOLD: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CNT_ONE;
        end else if (accept && code_ok) begin
          cnt_nx  = CNT_LOAD;
          word_nx = 8'b1 << dec.in_code;
        end else begin
          state_nx = IDLE;
          word_nx  = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        word_nx  = '0;
      end
    endcase
  end

  always_comb begin
    dec.in_ready  = en & ((state == IDLE) | (cnt == '0));
    dec.out       = word;
    dec.out_valid = (state == HOLD);
    busy          = (state == HOLD);
`ifdef DEC_PARITY_EN
    err           = err_q;
`endif
  end
endmodule

// File: tb/tb_decoder3x8_seq.sv
// Drives HOLD_CYCLES=1 and HOLD_CYCLES=4 decoders with a shared stream and checks both
// against a remaining-cycles reference model (parity model active under DEC_PARITY_EN).
module tb_decoder3x8_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en;
  logic busy1, busy4;
`ifdef DEC_PARITY_EN
  logic err1, err4;
`endif

  decoder3x8_seq_if if1 ();
  decoder3x8_seq_if if4 ();

  decoder3x8_seq #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .dec(if1.slave),
`ifdef DEC_PARITY_EN
    .err(err1),
`endif
    .busy(busy1)
  );

  decoder3x8_seq #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .dec(if4.slave),
`ifdef DEC_PARITY_EN
    .err(err4),
`endif
    .busy(busy4)
  );

  int errors = 0;
  int checks = 0;

  int         hold   [2] = '{1, 4};
  int         remain [2] = '{0, 0};
  logic [7:0] word_m [2] = '{8'h00, 8'h00};
  logic       err_m  [2] = '{1'b0, 1'b0};
  bit         known = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic get_act(input int k, output logic rdy, output logic [7:0] o,
                         output logic ov, output logic b, output logic e);
    e = 1'b0;
    if (k == 0) begin
      rdy = if1.in_ready; o = if1.out; ov = if1.out_valid; b = busy1;
`ifdef DEC_PARITY_EN
      e = err1;
`endif
    end else begin
      rdy = if4.in_ready; o = if4.out; ov = if4.out_valid; b = busy4;
`ifdef DEC_PARITY_EN
      e = err4;
`endif
    end
  endtask

  // One clock: drive at negedge, check ready before the edge, update model, check outputs after.
  task automatic cyc(input logic r, input logic e, input logic v, input logic [2:0] c, input logic p);
    logic       rdy_m [2];
    logic       a_rdy, a_ov, a_b, a_e, bad;
    logic [7:0] a_o;
    @(negedge clk);
    rst = r; en = e;
    if1.in_valid = v; if4.in_valid = v;
    if1.in_code  = c; if4.in_code  = c;
`ifdef DEC_PARITY_EN
    if1.in_parity = p; if4.in_parity = p;
    bad = ^{p, c};
`else
    bad = 1'b0;
`endif
    #1;
    for (int k = 0; k < 2; k++) begin
      rdy_m[k] = e && (remain[k] <= 1);
      if (known) begin
        get_act(k, a_rdy, a_o, a_ov, a_b, a_e);
        check_eq($sformatf("in_ready[h%0d]", hold[k]), a_rdy, rdy_m[k]);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        remain[k] = 0;
        err_m[k]  = 1'b0;
      end else begin
        err_m[k] = v && rdy_m[k] && bad;
        if (v && rdy_m[k] && !bad) begin
          word_m[k] = 8'h01 << c;
          remain[k] = hold[k];
        end else if (remain[k] > 0) begin
          remain[k] = remain[k] - 1;
        end
      end
      get_act(k, a_rdy, a_o, a_ov, a_b, a_e);
      check_eq($sformatf("out[h%0d]", hold[k]), a_o, (remain[k] > 0) ? word_m[k] : 8'h00);
      check_eq($sformatf("out_valid[h%0d]", hold[k]), a_ov, remain[k] > 0);
      check_eq($sformatf("busy[h%0d]", hold[k]), a_b, remain[k] > 0);
`ifdef DEC_PARITY_EN
      check_eq($sformatf("err[h%0d]", hold[k]), a_e, err_m[k]);
`endif
    end
    if (r) known = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    logic [2:0] rc;
    logic       rr, re, rv, rp;

    // reset held two clocks with en low
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

    // codes 0..7 back-to-back with correct parity
    for (int i = 0; i < 8; i++) begin
      rc = 3'(i);
      cyc(1'b0, 1'b1, 1'b1, rc, ^rc);
    end
    idle(6);

    // single code 5
    cyc(1'b0, 1'b1, 1'b1, 3'd5, 1'b0);
    idle(6);

    // code 2, then en drops with code 6 pending
    cyc(1'b0, 1'b1, 1'b1, 3'd2, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1, 3'd6, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 3'd6, 1'b0);
    idle(6);

    // reset on the second hold clock of code 7
    cyc(1'b0, 1'b1, 1'b1, 3'd7, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    idle(2);

    // code 3 with odd then even parity
    cyc(1'b0, 1'b1, 1'b1, 3'd3, 1'b1);
    idle(1);
    cyc(1'b0, 1'b1, 1'b1, 3'd3, 1'b0);
    idle(6);

    for (int i = 0; i < 500; i++) begin
      rr = ($urandom_range(0, 49) == 0);
      re = ($urandom_range(0, 7) != 0);
      rv = ($urandom_range(0, 3) != 0);
      rc = 3'($urandom_range(0, 7));
      rp = (^rc) ^ ($urandom_range(0, 3) == 0);
      cyc(rr, re, rv, rc, rp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
